// File: rtl/rob_param.sv
// rtl/rob_param.sv - parameterised reorder buffer; optional exception path enabled by macro ROB_EXC_EN
module rob_param #(
    parameter int DEPTH  = 16,
    parameter int XLEN   = 32,
    parameter int NUM_WB = 4,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    output logic [TAG_W-1:0]        alloc_tag,
    input  logic [4:0]              alloc_dest,
    input  logic                    alloc_reg_write,
    input  logic                    alloc_mem_write,
    input  logic [XLEN-1:0]         alloc_pc,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*TAG_W-1:0] wb_tag,
    input  logic [NUM_WB*XLEN-1:0]  wb_value,
    input  logic [NUM_WB-1:0]       wb_exc,
    input  logic [NUM_WB*2-1:0]     wb_cause,
    input  logic                    rb_valid,
    input  logic [TAG_W-1:0]        rb_tag,
    input  logic                    flush,
    output logic                    commit_valid,
    output logic [TAG_W-1:0]        commit_tag,
    output logic [4:0]              commit_dest,
    output logic [XLEN-1:0]         commit_value,
    output logic                    commit_reg_write,
    output logic                    commit_mem_write,
    output logic [XLEN-1:0]         commit_pc,
    output logic                    exc_valid,
    output logic [1:0]              exc_cause,
    output logic [XLEN-1:0]         exc_epc,
    output logic [TAG_W:0]          count,
    output logic                    full,
    output logic                    empty
);

    logic [TAG_W:0]   head, tail;
    logic [TAG_W-1:0] head_idx, tail_idx, rb_off;
    logic             commit_fire, exc_fire, rb_hit, alloc_fire;

    logic             e_valid [DEPTH];
    logic             e_ready [DEPTH];
    logic [4:0]       e_dest  [DEPTH];
    logic             e_rw    [DEPTH];
    logic             e_mw    [DEPTH];
    logic [XLEN-1:0]  e_pc    [DEPTH];
    logic [XLEN-1:0]  e_value [DEPTH];

    logic [DEPTH-1:0] wb_hit;
    logic [XLEN-1:0]  wb_val_sel [DEPTH];
    logic [DEPTH-1:0] kill;

`ifdef ROB_EXC_EN
    logic             e_exc   [DEPTH];
    logic [1:0]       e_cause [DEPTH];
    logic             wb_exc_sel   [DEPTH];
    logic [1:0]       wb_cause_sel [DEPTH];
`endif

    assign head_idx    = head[TAG_W-1:0];
    assign tail_idx    = tail[TAG_W-1:0];
    assign count       = tail - head;
    assign empty       = (head == tail);
    assign full        = (head[TAG_W] != tail[TAG_W]) && (head_idx == tail_idx);
    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;

    // Rollback target is measured as an age offset from the head; it must land on a live entry.
    assign rb_off     = rb_tag - head_idx;
    assign rb_hit     = rb_valid && ({1'b0, rb_off} < count);
    assign alloc_fire = alloc_valid && !full && !rb_valid;

`ifdef ROB_EXC_EN
    assign commit_fire = e_valid[head_idx] && e_ready[head_idx] && !e_exc[head_idx];
    assign exc_fire    = e_valid[head_idx] && e_ready[head_idx] &&  e_exc[head_idx];
`else
    assign commit_fire = e_valid[head_idx] && e_ready[head_idx];
    assign exc_fire    = 1'b0;
    logic unused_wb_exc;
    assign unused_wb_exc = ^{wb_exc, wb_cause};
`endif

    // Per-entry writeback select; channels scanned high to low so the lowest channel wins.
    always_comb begin
        wb_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wb_val_sel[i] = '0;
`ifdef ROB_EXC_EN
            wb_exc_sel[i]   = 1'b0;
            wb_cause_sel[i] = 2'b00;
`endif
            for (int c = NUM_WB - 1; c >= 0; c--) begin
                if (wb_valid[c] && (wb_tag[c*TAG_W +: TAG_W] == TAG_W'(i)) && e_valid[i]) begin
                    wb_hit[i]     = 1'b1;
                    wb_val_sel[i] = wb_value[c*XLEN +: XLEN];
`ifdef ROB_EXC_EN
                    wb_exc_sel[i]   = wb_exc[c];
                    wb_cause_sel[i] = wb_cause[c*2 +: 2];
`endif
                end
            end
        end
    end

    // Entries younger than the rollback target (but still live) are killed.
    always_comb begin : kill_gen
        logic [TAG_W-1:0] rel;
        kill = '0;
        rel  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = TAG_W'(i) - head_idx;
            kill[i] = rb_hit && (rel > rb_off) && ({1'b0, rel} < count);
        end
    end

    // Pointer and commit-port state; flush and head exception wipe the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0; tail <= '0;
            commit_valid <= 1'b0; commit_tag <= '0; commit_dest <= '0; commit_value <= '0;
            commit_reg_write <= 1'b0; commit_mem_write <= 1'b0; commit_pc <= '0;
        end else if (flush || exc_fire) begin
            head <= '0; tail <= '0;
            commit_valid <= 1'b0; commit_tag <= '0; commit_dest <= '0; commit_value <= '0;
            commit_reg_write <= 1'b0; commit_mem_write <= 1'b0; commit_pc <= '0;
        end else begin
            commit_valid     <= commit_fire;
            commit_tag       <= commit_fire ? head_idx          : '0;
            commit_dest      <= commit_fire ? e_dest[head_idx]  : '0;
            commit_value     <= commit_fire ? e_value[head_idx] : '0;
            commit_reg_write <= commit_fire && e_rw[head_idx];
            commit_mem_write <= commit_fire && e_mw[head_idx];
            commit_pc        <= commit_fire ? e_pc[head_idx]    : '0;
            if (commit_fire) head <= head + 1'b1;
            if (rb_hit) tail <= head + {1'b0, rb_off} + 1'b1;
            else if (alloc_fire) tail <= tail + 1'b1;
        end
    end

    // Entry storage: allocation, commit/rollback clearing, writeback completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_valid[i] <= 1'b0; e_ready[i] <= 1'b0; e_dest[i] <= '0; e_rw[i] <= 1'b0;
                e_mw[i] <= 1'b0; e_pc[i] <= '0; e_value[i] <= '0;
`ifdef ROB_EXC_EN
                e_exc[i] <= 1'b0; e_cause[i] <= 2'b00;
`endif
            end
        end else if (flush || exc_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_valid[i] <= 1'b0; e_ready[i] <= 1'b0;
`ifdef ROB_EXC_EN
                e_exc[i] <= 1'b0;
`endif
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_fire && (tail_idx == TAG_W'(i))) begin
                    e_valid[i] <= 1'b1; e_ready[i] <= 1'b0; e_dest[i] <= alloc_dest;
                    e_rw[i] <= alloc_reg_write; e_mw[i] <= alloc_mem_write; e_pc[i] <= alloc_pc;
`ifdef ROB_EXC_EN
                    e_exc[i] <= 1'b0;
`endif
                end else if (kill[i] || (commit_fire && (head_idx == TAG_W'(i)))) begin
                    e_valid[i] <= 1'b0; e_ready[i] <= 1'b0;
                end else if (wb_hit[i]) begin
                    e_ready[i] <= 1'b1;
                    e_value[i] <= wb_val_sel[i];
`ifdef ROB_EXC_EN
                    e_exc[i]   <= wb_exc_sel[i];
                    e_cause[i] <= wb_cause_sel[i];
`endif
                end
            end
        end
    end

`ifdef ROB_EXC_EN
    // One-cycle exception pulse carrying the faulting entry's cause and PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_valid <= 1'b0; exc_cause <= 2'b00; exc_epc <= '0;
        end else if (flush || !exc_fire) begin
            exc_valid <= 1'b0; exc_cause <= 2'b00; exc_epc <= '0;
        end else begin
            exc_valid <= 1'b1;
            exc_cause <= e_cause[head_idx];
            exc_epc   <= e_pc[head_idx];
        end
    end
`else
    assign exc_valid = 1'b0;
    assign exc_cause = 2'b00;
    assign exc_epc   = '0;
`endif

endmodule

// File: doc/rob_param.md
ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count (power of two, 4..256); TAG_W = log2(DEPTH) is derived.
REQ-002 SHALL have parameter XLEN, default 32, width of data and PC fields.
REQ-003 SHALL have parameter NUM_WB, default 4, number of writeback channels.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports: clk  in  1  clock, rising-edge; rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: alloc_valid  in  1  allocate request; alloc_ready  out  1  not full; alloc_tag  out  TAG_W  tag assigned to current request.
REQ-007 SHALL have ports: alloc_dest  in  5  rd; alloc_reg_write  in  1  rd write; alloc_mem_write  in  1  store; alloc_pc  in  XLEN  instruction PC.
REQ-008 SHALL have ports: wb_valid  in  NUM_WB  per-channel done; wb_tag  in  NUM_WB*TAG_W; wb_value  in  NUM_WB*XLEN; wb_exc  in  NUM_WB; wb_cause  in  NUM_WB*2 (channel c in slice c).
REQ-009 SHALL have ports: rb_valid  in  1  mispredict rollback; rb_tag  in  TAG_W  youngest surviving tag; flush  in  1  synchronous clear.
REQ-010 SHALL have ports: commit_valid  out  1; commit_tag  out  TAG_W; commit_dest  out  5; commit_value  out  XLEN; commit_reg_write  out  1; commit_mem_write  out  1; commit_pc  out  XLEN.
REQ-011 SHALL have ports: exc_valid  out  1; exc_cause  out  2; exc_epc  out  XLEN; count  out  TAG_W+1; full  out  1; empty  out  1.

Function
REQ-012 SHALL keep head/tail pointers of TAG_W+1 bits (MSB = wrap bit); full = index equal and wrap differ; empty = pointers equal; count = tail-head.
REQ-013 SHALL drive alloc_ready = !full and alloc_tag = tail index combinationally from registers.
REQ-014 SHALL, on alloc_valid && alloc_ready, write {valid=1, ready=0, exc=0, dest, reg_write, mem_write, pc} at tail and increment tail modulo 2*DEPTH; alloc_valid while full is dropped.
REQ-015 SHALL, per channel, on wb_valid to a valid entry, set ready=1 and store value; writeback to an invalid entry is ignored.
REQ-016 SHALL, when several channels hit one tag in a cycle, apply the lowest-numbered channel only.
REQ-017 SHALL evaluate head from registered state: head valid, ready, exc=0 -> on that edge register commit_* from entry, commit_valid=1, clear entry, head+1; otherwise commit_valid=0 and all commit_* data 0.
REQ-018 SHALL give latency: writeback sampled at edge k -> commit_valid visible after edge k+1 at earliest; one commit per cycle.
REQ-019 SHALL, on rb_valid with rb_tag inside [head, tail), set tail so that count = ((rb_tag - head index) mod DEPTH) + 1 and invalidate all younger entries; an out-of-range rb_tag is ignored.
REQ-020 SHALL ignore allocation in a cycle with rb_valid=1; a head commit in the same cycle proceeds, and count reflects both.
REQ-021 SHALL apply the priority: reset > flush > head exception > rollback > allocation; writeback and commit proceed unless flush or exception occurs.
REQ-022 SHALL, on flush, clear every entry, set head=tail=0, and drive commit_valid=0 and exc_valid=0 on the next cycle.
REQ-023 SHALL let full and empty coexist only as mutually exclusive; allocate and commit in the same cycle when full is blocked (full is sampled pre-edge).

Reset
REQ-024 SHALL, on rst low, asynchronously clear all entries, head=tail=0, and all outputs 0 except alloc_ready=1 and empty=1.
REQ-025 SHALL treat reset mid-operation as discarding all in-flight entries with no commit or exception pulse.

Configuration
REQ-026 SHALL provide macro ROB_EXC_EN: when defined, wb_exc/wb_cause are stored per entry; a ready head with exc=1 pulses exc_valid for one cycle with exc_cause and exc_epc=entry pc, commits nothing, and clears the ROB as flush does.
REQ-027 SHALL, without ROB_EXC_EN, ignore wb_exc/wb_cause, store no cause bits, and tie exc_valid, exc_cause and exc_epc to 0.

Verification
REQ-028 SHALL cover: reset, 16 allocs (pc 0x100+4n), no wb -> full=1 after 16th, 17th dropped, alloc_ready=0, count=16.
REQ-029 SHALL cover: out-of-order wb tags 2,1,0 values 0xA,0xB,0xC -> commits tag0=0xC, tag1=0xB, tag2=0xA on consecutive cycles.
REQ-030 SHALL cover: channels 0 and 3 same cycle same tag 5 values 0x11/0x33 -> commit_value=0x11 for tag 5.
REQ-031 SHALL cover: 8 entries head=0, rb_tag=3 -> count=4, next alloc_tag=4, later wb to tag 6 ignored.
REQ-032 SHALL cover, with ROB_EXC_EN: wb tag0 exc=1 cause=2'b01 pc 0x100 -> exc_valid one cycle, exc_epc=0x100, exc_cause=1, empty=1, no commit; without the macro, tag0 commits normally.
REQ-033 SHALL cover: rst low during wrap (head=14, tail=2) -> immediately empty=1, count=0, commit_valid=0.
